// File: rtl/decoder_x4_seq.sv
// decoder_x4_seq: sequenced 2-to-4 decoder with a 2-entry code queue.
// Each accepted 2-bit code becomes a one-hot pulse on `out` lasting HOLD
// cycles. Codes arriving while a pulse is active wait in the queue; a code
// offered while the queue is full is lost and reported on `drop`.
//
// Optional feature macro: DECODER_X4_GAP_EN
//   defined   - a GAP state follows every pulse, so pulses are separated by
//               at least two zero cycles (GAP + IDLE pop)
//   undefined - queued codes produce abutting pulses
module decoder_x4_seq #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] in,
    input  logic       flag,
    output logic       ready,
    output logic [3:0] out,
    output logic       busy,
    output logic       drop
);

    // Counter reload value; HOLD is restricted to 1..15 so it fits 4 bits.
    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

`ifdef DECODER_X4_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1
    } state_t;
`endif

    // Map a 2-bit code onto its one-hot pulse pattern.
    function automatic logic [3:0] onehot_f(input logic [1:0] code);
        logic [3:0] res;
        case (code)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    state_t     state_r;
    logic [3:0] cnt_r;
    logic [1:0] count_r;
    logic [1:0] q0_r;
    logic [1:0] q1_r;
    logic [3:0] out_r;
    logic       busy_r;
    logic       drop_r;

    logic       push_s;
    logic       pop_s;
    logic [1:0] count_nxt_s;

    // ready is derived from the registered count only, gated by reset and enable.
    assign ready = rst_n & enable & (count_r != 2'd2);
    assign out   = out_r;
    assign busy  = busy_r;
    assign drop  = drop_r;

    // Decide queue push/pop for this edge and the resulting queue occupancy.
    always_comb begin
        push_s      = flag & ready;
        pop_s       = 1'b0;
        count_nxt_s = count_r;
        if (enable && (count_r != 2'd0)) begin
            case (state_r)
                ST_IDLE:  pop_s = 1'b1;
`ifdef DECODER_X4_GAP_EN
                ST_PULSE: pop_s = 1'b0;
`else
                ST_PULSE: pop_s = (cnt_r == 4'd0);
`endif
                default:  pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Two-entry FIFO: q0_r is always the head; a same-edge push and pop keeps count.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            count_r <= 2'd0;
            q0_r    <= 2'd0;
            q1_r    <= 2'd0;
        end else begin
            count_r <= count_nxt_s;
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        q0_r <= in;
                    end else begin
                        q1_r <= in;
                    end
                end
                2'b01: begin
                    q0_r <= q1_r;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        q0_r <= in;
                    end else begin
                        q0_r <= q1_r;
                        q1_r <= in;
                    end
                end
                default: begin
                    q0_r <= q0_r;
                end
            endcase
        end
    end

    // Pulse sequencer with registered out/busy/drop; disable flushes like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            out_r   <= 4'b0000;
            busy_r  <= 1'b0;
            drop_r  <= 1'b0;
        end else begin
            // A code offered while the queue is full is lost.
            drop_r <= flag & ~ready;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        out_r   <= onehot_f(q0_r);
                        cnt_r   <= HOLD_M1;
                        state_r <= ST_PULSE;
                        busy_r  <= 1'b1;
                    end else begin
                        out_r   <= 4'b0000;
                        cnt_r   <= 4'd0;
                        busy_r  <= (count_nxt_s != 2'd0);
                    end
                end
                ST_PULSE: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r  <= cnt_r - 4'd1;
                        busy_r <= 1'b1;
                    end else begin
`ifdef DECODER_X4_GAP_EN
                        state_r <= ST_GAP;
                        out_r   <= 4'b0000;
                        busy_r  <= 1'b1;
`else
                        if (pop_s) begin
                            // Back-to-back: next code starts without a zero cycle.
                            out_r  <= onehot_f(q0_r);
                            cnt_r  <= HOLD_M1;
                            busy_r <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            out_r   <= 4'b0000;
                            busy_r  <= (count_nxt_s != 2'd0);
                        end
`endif
                    end
                end
`ifdef DECODER_X4_GAP_EN
                ST_GAP: begin
                    state_r <= ST_IDLE;
                    out_r   <= 4'b0000;
                    cnt_r   <= 4'd0;
                    busy_r  <= (count_nxt_s != 2'd0);
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    out_r   <= 4'b0000;
                    cnt_r   <= 4'd0;
                    busy_r  <= (count_nxt_s != 2'd0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_x4_seq.sv
// Scoreboard bench for decoder_x4_seq: two instances (HOLD=4 and HOLD=1)
// share the same stimulus; a behavioural model predicts each cycle's outputs,
// the driver queues them and a monitor compares after every rising edge.
module tb_decoder_x4_seq;

    localparam int HOLD_A = 4;
    localparam int HOLD_B = 1;

    typedef struct {
        logic [3:0] out;
        logic       busy;
        logic       drop;
        logic       ready;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] code = 2'd0;
    logic       flag = 1'b0;

    logic       ready0, busy0, drop0;
    logic [3:0] out0;
    logic       ready1, busy1, drop1;
    logic [3:0] out1;

    int checks = 0;
    int failures = 0;

    exp_t expq0[$];
    exp_t expq1[$];

    // Reference model state per instance: pending codes, current pulse, gap cycles owed.
    int         qn[2];
    logic [1:0] qv[2][2];
    int         cur[2];
    int         rem[2];
    int         gp[2];

    decoder_x4_seq #(.HOLD(HOLD_A)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in(code), .flag(flag),
        .ready(ready0), .out(out0), .busy(busy0), .drop(drop0)
    );

    decoder_x4_seq #(.HOLD(HOLD_B)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in(code), .flag(flag),
        .ready(ready1), .out(out1), .busy(busy1), .drop(drop1)
    );

    always #5 clk = ~clk;

    task automatic start_pulse(input int i, input int hold);
        cur[i]   = int'(qv[i][0]);
        qv[i][0] = qv[i][1];
        qn[i]    = qn[i] - 1;
        rem[i]   = hold;
    endtask

    // Predict outputs after the next edge from the decoder's behavioural rules.
    task automatic model_step(input int i, input int hold, input logic r, input logic en,
                              input logic f, input logic [1:0] c, output exp_t e);
        int   pre;
        logic rdy;
        e.drop = 1'b0;
        if (!r || !en) begin
            qn[i] = 0; cur[i] = -1; rem[i] = 0; gp[i] = 0;
        end else begin
            pre = qn[i];
            rdy = (pre < 2);
            e.drop = f && !rdy;
            if (cur[i] >= 0) begin
                rem[i] = rem[i] - 1;
                if (rem[i] == 0) begin
                    cur[i] = -1;
`ifdef DECODER_X4_GAP_EN
                    gp[i] = 1;
`else
                    if (pre > 0) start_pulse(i, hold);
`endif
                end
            end else if (gp[i] > 0) begin
                gp[i] = gp[i] - 1;
            end else if (pre > 0) begin
                start_pulse(i, hold);
            end
            if (f && rdy) begin
                qv[i][qn[i]] = c;
                qn[i] = qn[i] + 1;
            end
        end
        e.out   = (cur[i] >= 0) ? 4'(1 << cur[i]) : 4'b0000;
        e.busy  = (cur[i] >= 0) || (gp[i] > 0) || (qn[i] > 0);
        e.ready = r && en && (qn[i] < 2);
    endtask

    // Drive one cycle of inputs at the falling edge and queue the predictions.
    task automatic cycle(input logic r, input logic en, input logic f, input logic [1:0] c);
        exp_t e0, e1;
        @(negedge clk);
        rst_n = r; enable = en; flag = f; code = c;
        model_step(0, HOLD_A, r, en, f, c, e0);
        expq0.push_back(e0);
        model_step(1, HOLD_B, r, en, f, c, e1);
        expq1.push_back(e1);
    endtask

    task automatic compare(input string name, input exp_t e, input logic [3:0] o,
                           input logic b, input logic d, input logic rd);
        checks++;
        if ({o, b, d, rd} !== {e.out, e.busy, e.drop, e.ready}) begin
            failures++;
            $display("FAIL %s t=%0t: got out=%b busy=%b drop=%b ready=%b, expected out=%b busy=%b drop=%b ready=%b",
                     name, $time, o, b, d, rd, e.out, e.busy, e.drop, e.ready);
        end
    endtask

    // Monitor: one prediction per instance per edge, sampled 1 time unit after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expq0.size() > 0) begin
            e = expq0.pop_front();
            compare("hold4", e, out0, busy0, drop0, ready0);
        end
        if (expq1.size() > 0) begin
            e = expq1.pop_front();
            compare("hold1", e, out1, busy1, drop1, ready1);
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            qn[i] = 0; cur[i] = -1; rem[i] = 0; gp[i] = 0;
        end

        // Reset with flag held high: no drop, ready returns after release.
        cycle(1'b0, 1'b1, 1'b1, 2'd3);
        cycle(1'b0, 1'b1, 1'b1, 2'd3);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 2'd0);

        // Single code 2.
        cycle(1'b1, 1'b1, 1'b1, 2'd2);
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 2'd0);

        // Burst 1, 3, 0.
        cycle(1'b1, 1'b1, 1'b1, 2'd1);
        cycle(1'b1, 1'b1, 1'b1, 2'd3);
        cycle(1'b1, 1'b1, 1'b1, 2'd0);
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 2'd0);

        // Overflow 0, 1, 2, 3: last code dropped on the HOLD=4 instance.
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b1, 2'(k));
        repeat (25) cycle(1'b1, 1'b1, 1'b0, 2'd0);

        // Enable removed during the second cycle of a pulse with a code queued.
        cycle(1'b1, 1'b1, 1'b1, 2'd2);
        cycle(1'b1, 1'b1, 1'b1, 2'd1);
        cycle(1'b1, 1'b1, 1'b0, 2'd0);
        cycle(1'b1, 1'b0, 1'b1, 2'd3);
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 2'd0);

        // Back-to-back walk 0..3 (single-cycle pulses on the HOLD=1 instance).
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b1, 2'(k));
        repeat (25) cycle(1'b1, 1'b1, 1'b0, 2'd0);

        // Randomized traffic with occasional disable and reset.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) != 0),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        repeat (30) cycle(1'b1, 1'b1, 1'b0, 2'd0);

        // Let the monitor consume the remaining predictions, bounded.
        for (int w = 0; w < 10 && (expq0.size() > 0 || expq1.size() > 0); w++) @(posedge clk);
        #2;
        checks++;
        if (expq0.size() != 0 || expq1.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d predictions left, expected 0/0", expq0.size(), expq1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
